uart_rx_byte: RTL and testbench

UART receiver that turns the serial `uart_line_in` stream into bytes for the core's byte-level UART endpoint, carrying data from the host toward the design. It accepts 8N1 frames at a fixed bit period, validates start and stop bits, and holds one received byte behind a valid/ready handshake. It sits between the board receive pin and the core-side consumer.

---
 rtl/uart_rx_byte.sv | 248 ++++++++++++++++++++++++
 tb/tb_uart_rx_byte.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_byte.sv
// uart_rx_byte: UART receiver (8N1) with a one-byte holding register behind a valid/ready handshake.
// Define UART_RX_PARITY_EN to receive 8E1 frames (adds the PARITY state and even-parity check).
module uart_rx_byte #(
  parameter int CLKS_PER_BIT = 139
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       uart_line_in,
  output logic [7:0] data_out,
  output logic       valid_out,
  input  logic       ready_in,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_LOAD = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_LOAD = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_ZERO  = CW'(0);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_STOP      = 3'd3,
    ST_WAIT_HIGH = 3'd4,
    ST_PARITY    = 3'd5
  } state_t;

  function automatic logic even_parity(input logic [7:0] d);
    return ^d;
  endfunction
`else
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_STOP      = 3'd3,
    ST_WAIT_HIGH = 3'd4
  } state_t;
`endif

  state_t        r_state;
  state_t        w_next;
  logic          r_sync1;
  logic          r_sync2;
  logic          w_rx_s;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_idx;
  logic [7:0]    r_shift;
  logic          w_expired;
  logic          w_par_bad;
  logic          w_load_half;
  logic          w_load_full;
  logic          w_shift_en;
  logic          w_deliver;
  logic          w_frame_err;
  logic          w_overrun;
`ifdef UART_RX_PARITY_EN
  logic          r_par_err;
  logic          w_par_capture;
`endif

  assign w_rx_s    = r_sync2;
  assign w_expired = (r_cnt == CNT_ZERO);
`ifdef UART_RX_PARITY_EN
  assign w_par_bad = r_par_err;
`else
  assign w_par_bad = 1'b0;
`endif

  // Two-flop synchronizer for the asynchronous line; idles high.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= uart_line_in;
      r_sync2 <= r_sync1;
    end
  end

  // State register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (!w_rx_s) w_next = ST_START;
        else         w_next = ST_IDLE;
      end
      ST_START: begin
        if (w_expired) begin
          if (!w_rx_s) w_next = ST_DATA;
          else         w_next = ST_IDLE;
        end else begin
          w_next = ST_START;
        end
      end
      ST_DATA: begin
        if (w_expired && (r_idx == 3'd7)) begin
`ifdef UART_RX_PARITY_EN
          w_next = ST_PARITY;
`else
          w_next = ST_STOP;
`endif
        end else begin
          w_next = ST_DATA;
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (w_expired) w_next = ST_STOP;
        else           w_next = ST_PARITY;
      end
`endif
      ST_STOP: begin
        if (w_expired) begin
          if (w_rx_s) w_next = ST_IDLE;
          else        w_next = ST_WAIT_HIGH;
        end else begin
          w_next = ST_STOP;
        end
      end
      ST_WAIT_HIGH: begin
        if (w_rx_s) w_next = ST_IDLE;
        else        w_next = ST_WAIT_HIGH;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Per-state control strobes for the datapath.
  always_comb begin
    w_load_half   = 1'b0;
    w_load_full   = 1'b0;
    w_shift_en    = 1'b0;
    w_deliver     = 1'b0;
    w_frame_err   = 1'b0;
    w_overrun     = 1'b0;
`ifdef UART_RX_PARITY_EN
    w_par_capture = 1'b0;
`endif
    case (r_state)
      ST_IDLE: begin
        if (!w_rx_s) w_load_half = 1'b1;
        else         w_load_half = 1'b0;
      end
      ST_START: begin
        if (w_expired && !w_rx_s) w_load_full = 1'b1;
        else                      w_load_full = 1'b0;
      end
      ST_DATA: begin
        if (w_expired) begin
          w_shift_en  = 1'b1;
          w_load_full = 1'b1;
        end else begin
          w_shift_en  = 1'b0;
          w_load_full = 1'b0;
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (w_expired) begin
          w_par_capture = 1'b1;
          w_load_full   = 1'b1;
        end else begin
          w_par_capture = 1'b0;
          w_load_full   = 1'b0;
        end
      end
`endif
      ST_STOP: begin
        if (w_expired) begin
          if (w_rx_s && !w_par_bad) begin
            // A byte may land in a holding register that is draining this same cycle.
            if (!valid_out || ready_in) w_deliver = 1'b1;
            else                        w_overrun = 1'b1;
          end else begin
            w_frame_err = 1'b1;
          end
        end else begin
          w_deliver = 1'b0;
        end
      end
      ST_WAIT_HIGH: w_deliver = 1'b0;
      default:      w_deliver = 1'b0;
    endcase
  end

  // Bit timing, shift register, holding register and registered flags.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_cnt     <= CNT_ZERO;
      r_idx     <= 3'd0;
      r_shift   <= 8'h00;
      data_out  <= 8'h00;
      valid_out <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      busy      <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par_err <= 1'b0;
`endif
    end else begin
      if (w_load_half)      r_cnt <= HALF_LOAD;
      else if (w_load_full) r_cnt <= FULL_LOAD;
      else if (!w_expired)  r_cnt <= r_cnt - CW'(1);
      else                  r_cnt <= r_cnt;

      if (w_load_half)     r_idx <= 3'd0;
      else if (w_shift_en) r_idx <= r_idx + 3'd1;
      else                 r_idx <= r_idx;

      if (w_shift_en) r_shift[r_idx] <= w_rx_s;

`ifdef UART_RX_PARITY_EN
      if (w_load_half)        r_par_err <= 1'b0;
      else if (w_par_capture) r_par_err <= (w_rx_s != even_parity(r_shift));
      else                    r_par_err <= r_par_err;
`endif

      frame_err <= w_frame_err;
      overrun   <= w_overrun;
      busy      <= (w_next != ST_IDLE);

      if (w_deliver) begin
        data_out  <= r_shift;
        valid_out <= 1'b1;
      end else if (valid_out && ready_in) begin
        valid_out <= 1'b0;
      end else begin
        valid_out <= valid_out;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_byte.sv
// Directed self-checking bench for uart_rx_byte at CLKS_PER_BIT=16.
// Frames carry an even-parity bit when UART_RX_PARITY_EN is defined.
module tb_uart_rx_byte;

  localparam int C = 16;
`ifdef UART_RX_PARITY_EN
  localparam int STOP_OFS = 10;
`else
  localparam int STOP_OFS = 9;
`endif
  // pin->rx_s (2) + start half-bit + bit periods to the stop sample + 1 registered output cycle
  localparam int LAT = 2 + C / 2 + STOP_OFS * C + 1;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       line = 1'b1;
  logic       ready = 1'b0;
  logic [7:0] data_out;
  logic       valid_out;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int n_cmp = 0;
  int n_bad = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  logic [7:0] acc_q[$];

  always #5 CLK = ~CLK;

  uart_rx_byte #(.CLKS_PER_BIT(C)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .uart_line_in(line),
    .data_out    (data_out),
    .valid_out   (valid_out),
    .ready_in    (ready),
    .frame_err   (frame_err),
    .overrun     (overrun),
    .busy        (busy)
  );

  // Inputs change just after posedge; the monitor samples pulses and accepted bytes at negedge.
  always @(negedge CLK) begin
    if (frame_err === 1'b1) fe_cnt++;
    if (overrun === 1'b1) ov_cnt++;
    if (valid_out === 1'b1 && ready === 1'b1) acc_q.push_back(data_out);
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic flip_par);
    line = 1'b0;
    step(C);
    for (int i = 0; i < 8; i++) begin
      line = b[i];
      step(C);
    end
`ifdef UART_RX_PARITY_EN
    line = (^b) ^ flip_par;
    step(C);
`else
    if (flip_par) line = 1'b1;
    else          line = 1'b1;
`endif
    line = 1'b1;
    step(C);
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_frame(b, 1'b0);
  endtask

  task automatic test_reset();
    RST = 1'b1;
    step(3);
    n_cmp++; if (data_out !== 8'h00) begin n_bad++; $display("FAIL reset_data: got %h want 00", data_out); end
    n_cmp++; if (valid_out !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", valid_out); end
    n_cmp++; if (frame_err !== 1'b0) begin n_bad++; $display("FAIL reset_ferr: got %b want 0", frame_err); end
    n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL reset_ovr: got %b want 0", overrun); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    RST = 1'b0;
    step(3);
    n_cmp++; if (busy !== 1'b0 || valid_out !== 1'b0) begin n_bad++; $display("FAIL post_reset_idle: got busy=%b valid=%b want 0 0", busy, valid_out); end
  endtask

  task automatic test_single();
    int fe0 = fe_cnt;
    int ov0 = ov_cnt;
    int q0;
    int lat = 0;
    ready = 1'b0;
    fork
      send_byte(8'hA5);
      begin
        for (int n = 1; n <= LAT + 40; n++) begin
          @(posedge CLK);
          #1;
          if (valid_out === 1'b1) begin
            lat = n;
            break;
          end
        end
      end
    join
    n_cmp++; if (lat != LAT) begin n_bad++; $display("FAIL single_latency: got %0d want %0d", lat, LAT); end
    n_cmp++; if (data_out !== 8'hA5) begin n_bad++; $display("FAIL single_data: got %h want a5", data_out); end
    n_cmp++; if (fe_cnt - fe0 != 0 || ov_cnt - ov0 != 0) begin n_bad++; $display("FAIL single_flags: got fe=%0d ov=%0d want 0 0", fe_cnt - fe0, ov_cnt - ov0); end
    q0 = acc_q.size();
    ready = 1'b1;
    step(2);
    ready = 1'b0;
    n_cmp++; if (valid_out !== 1'b0) begin n_bad++; $display("FAIL single_drain_valid: got %b want 0", valid_out); end
    n_cmp++; if (acc_q.size() != q0 + 1 || acc_q[q0] !== 8'hA5) begin n_bad++; $display("FAIL single_accept: got size=%0d want %0d with a5", acc_q.size(), q0 + 1); end
  endtask

  task automatic test_back_to_back();
    int ov0 = ov_cnt;
    int fe0 = fe_cnt;
    int q0 = acc_q.size();
    ready = 1'b1;
    send_byte(8'h3C);
    send_byte(8'h81);
    step(10);
    ready = 1'b0;
    n_cmp++; if (acc_q.size() != q0 + 2) begin n_bad++; $display("FAIL b2b_count: got %0d want %0d", acc_q.size() - q0, 2); end
    n_cmp++; if (acc_q.size() < q0 + 1 || acc_q[q0] !== 8'h3C) begin n_bad++; $display("FAIL b2b_first: got size=%0d want byte 3c", acc_q.size() - q0); end
    n_cmp++; if (acc_q.size() < q0 + 2 || acc_q[q0 + 1] !== 8'h81) begin n_bad++; $display("FAIL b2b_second: got size=%0d want byte 81", acc_q.size() - q0); end
    n_cmp++; if (ov_cnt - ov0 != 0 || fe_cnt - fe0 != 0) begin n_bad++; $display("FAIL b2b_flags: got ov=%0d fe=%0d want 0 0", ov_cnt - ov0, fe_cnt - fe0); end
  endtask

  task automatic test_overrun();
    int ov0 = ov_cnt;
    int q0;
    ready = 1'b0;
    send_byte(8'h11);
    send_byte(8'h22);
    step(10);
    n_cmp++; if (data_out !== 8'h11) begin n_bad++; $display("FAIL ovr_hold_data: got %h want 11", data_out); end
    n_cmp++; if (valid_out !== 1'b1) begin n_bad++; $display("FAIL ovr_hold_valid: got %b want 1", valid_out); end
    n_cmp++; if (ov_cnt - ov0 != 1) begin n_bad++; $display("FAIL ovr_pulses: got %0d want 1", ov_cnt - ov0); end
    q0 = acc_q.size();
    ready = 1'b1;
    step(2);
    ready = 1'b0;
    n_cmp++; if (acc_q.size() != q0 + 1 || acc_q[q0] !== 8'h11) begin n_bad++; $display("FAIL ovr_drain: got size=%0d want %0d with 11", acc_q.size(), q0 + 1); end
    n_cmp++; if (valid_out !== 1'b0) begin n_bad++; $display("FAIL ovr_valid_clear: got %b want 0", valid_out); end
  endtask

  task automatic test_glitch();
    int fe0 = fe_cnt;
    int n_end = 0;
    logic saw = 1'b0;
    fork
      begin
        line = 1'b0;
        step(5);
        line = 1'b1;
      end
      begin
        for (int n = 1; n <= 60; n++) begin
          step(1);
          if (busy === 1'b1) saw = 1'b1;
          else if (saw) begin
            n_end = n;
            break;
          end
        end
      end
    join
    n_cmp++; if (!(saw && n_end >= 1 && n_end <= C / 2 + 3)) begin n_bad++; $display("FAIL glitch_busy: got busy-seen=%b idle-after=%0d want 1 and <=%0d", saw, n_end, C / 2 + 3); end
    step(4);
    n_cmp++; if (valid_out !== 1'b0) begin n_bad++; $display("FAIL glitch_valid: got %b want 0", valid_out); end
    n_cmp++; if (fe_cnt - fe0 != 0) begin n_bad++; $display("FAIL glitch_ferr: got %0d want 0", fe_cnt - fe0); end
  endtask

  task automatic test_break();
    int fe0 = fe_cnt;
    line = 1'b0;
    step(20 * C);
    line = 1'b1;
    step(C);
    n_cmp++; if (fe_cnt - fe0 != 1) begin n_bad++; $display("FAIL break_ferr: got %0d want 1", fe_cnt - fe0); end
    n_cmp++; if (valid_out !== 1'b0) begin n_bad++; $display("FAIL break_valid: got %b want 0", valid_out); end
    send_byte(8'h55);
    step(5);
    n_cmp++; if (valid_out !== 1'b1 || data_out !== 8'h55) begin n_bad++; $display("FAIL break_recover: got valid=%b data=%h want 1 55", valid_out, data_out); end
    n_cmp++; if (fe_cnt - fe0 != 1) begin n_bad++; $display("FAIL break_single_ferr: got %0d want 1", fe_cnt - fe0); end
    ready = 1'b1;
    step(2);
    ready = 1'b0;
  endtask

  task automatic test_mid_reset();
    int fe0 = fe_cnt;
    int q0 = acc_q.size();
    ready = 1'b0;
    fork
      send_byte(8'hF8);
      begin
        step(5 * C + C / 2);
        RST = 1'b1;
        step(1);
        n_cmp++; if (data_out !== 8'h00 || valid_out !== 1'b0) begin n_bad++; $display("FAIL midrst_data: got data=%h valid=%b want 00 0", data_out, valid_out); end
        n_cmp++; if (frame_err !== 1'b0 || overrun !== 1'b0) begin n_bad++; $display("FAIL midrst_flags: got fe=%b ov=%b want 0 0", frame_err, overrun); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL midrst_busy: got %b want 0", busy); end
        step(2);
        RST = 1'b0;
      end
    join
    step(C);
    fe0 = fe_cnt - fe0;
    n_cmp++; if (valid_out !== 1'b0 || acc_q.size() != q0 || fe0 != 0) begin n_bad++; $display("FAIL midrst_partial_lost: got valid=%b accepted=%0d fe=%0d want 0 0 0", valid_out, acc_q.size() - q0, fe0); end
    send_byte(8'h0F);
    step(5);
    n_cmp++; if (valid_out !== 1'b1 || data_out !== 8'h0F) begin n_bad++; $display("FAIL midrst_recover: got valid=%b data=%h want 1 0f", valid_out, data_out); end
    ready = 1'b1;
    step(2);
    ready = 1'b0;
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity_err();
    int fe0 = fe_cnt;
    send_frame(8'h0F, 1'b1);
    step(5);
    n_cmp++; if (fe_cnt - fe0 != 1) begin n_bad++; $display("FAIL parity_ferr: got %0d want 1", fe_cnt - fe0); end
    n_cmp++; if (valid_out !== 1'b0) begin n_bad++; $display("FAIL parity_valid: got %b want 0", valid_out); end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_overrun();
    test_glitch();
    test_break();
    test_mid_reset();
`ifdef UART_RX_PARITY_EN
    test_parity_err();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
